spi_slave_fifo: RTL

Parametrised SPI slave that generalises the single-word slave to all four SPI modes, configurable bit order and multi-word frames. Data is buffered through TX and RX FIFOs so that the host side and the SPI side are decoupled. It sits between an external SPI master (pins) and on-chip logic clocked by `i_clk`. All SPI pins are oversampled through 2-flop synchronisers.

---
 rtl/spi_slave_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
// SPI slave (any CPOL/CPHA, either bit order, multi-word frames) with TX/RX FIFOs to the host.
// SPI pins are synchronised into i_clk; pin activity is acted on two i_clk edges after capture.
module spi_slave_fifo #(
  parameter int unsigned p_WORD_LEN   = 8,
  parameter int unsigned p_FIFO_DEPTH = 4,
  parameter bit          p_CPOL       = 1'b0,
  parameter bit          p_CPHA       = 1'b0,
  parameter bit          p_LSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [p_WORD_LEN-1:0] inp_data,
  input  logic                  inp_en,
  output logic                  inp_rdy,
  output logic [p_WORD_LEN-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_en,
  output logic                  o_busy,
  output logic                  o_ovf,
  output logic                  o_udf,
  input  logic                  i_clr_err
);

  localparam int unsigned AW = $clog2(p_FIFO_DEPTH);
  localparam int unsigned CW = $clog2(p_WORD_LEN + 1);
  localparam logic [CW-1:0] LastBit = CW'(p_WORD_LEN - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);

  typedef enum logic {StIdle, StFrame} state_e;

  logic r_sclk_s1, r_sclk_s2, r_sclk_q;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2, r_ss_q;

  state_e                r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [p_WORD_LEN-1:0] r_rx_shift;
  logic [p_WORD_LEN-1:0] r_tx_shift;

  logic [p_WORD_LEN-1:0] r_tx_mem [p_FIFO_DEPTH];
  logic [p_WORD_LEN-1:0] r_rx_mem [p_FIFO_DEPTH];
  logic [AW:0]           r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;

  logic w_sclk_edge, w_lead, w_trail, w_sample_edge, w_drive_edge;
  logic w_ss_fall, w_ss_rise, w_in_frame, w_sample, w_drive, w_word_done, w_tx_load;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_ovf_set, w_udf_set;
  logic                  w_tx_head, w_ld_head;
  logic [p_WORD_LEN-1:0] w_tx_word, w_tx_next, w_ld_next, w_rx_word;

  // SS synchronisers reset low so SS held low across reset cannot look like a falling edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sclk_s1 <= p_CPOL;
      r_sclk_s2 <= p_CPOL;
      r_sclk_q  <= p_CPOL;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_q    <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_q  <= r_sclk_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= i_ss;
      r_ss_s2   <= r_ss_s1;
      r_ss_q    <= r_ss_s2;
    end
  end

  assign w_sclk_edge   = r_sclk_s2 ^ r_sclk_q;
  assign w_lead        = w_sclk_edge & (r_sclk_s2 ^ p_CPOL);
  assign w_trail       = w_sclk_edge & ~(r_sclk_s2 ^ p_CPOL);
  assign w_sample_edge = p_CPHA ? w_trail : w_lead;
  assign w_drive_edge  = p_CPHA ? w_lead : w_trail;
  assign w_ss_fall     = r_ss_q & ~r_ss_s2;
  assign w_ss_rise     = ~r_ss_q & r_ss_s2;

  assign w_in_frame  = (r_state == StFrame) && !w_ss_rise;
  assign w_sample    = w_in_frame && w_sample_edge;
  assign w_drive     = w_in_frame && w_drive_edge;
  assign w_word_done = w_sample && (r_bit_cnt == LastBit);
  assign w_tx_load   = ((r_state == StIdle) && w_ss_fall) || w_word_done;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);

  assign w_tx_push = inp_en && !w_tx_full;
  assign w_tx_pop  = w_tx_load && !w_tx_empty;
  assign w_udf_set = w_tx_load && w_tx_empty;
  assign w_tx_word = w_tx_empty ? '0 : r_tx_mem[r_tx_rd[AW-1:0]];

  // A same-cycle host pop frees the slot the completing word needs.
  assign w_rx_pop  = out_en && !w_rx_empty;
  assign w_rx_push = w_word_done && (!w_rx_full || w_rx_pop);
  assign w_ovf_set = w_word_done && w_rx_full && !w_rx_pop;

  assign w_rx_word = p_LSB_FIRST ? {r_mosi_s2, r_rx_shift[p_WORD_LEN-1:1]}
                                 : {r_rx_shift[p_WORD_LEN-2:0], r_mosi_s2};
  assign w_tx_head = p_LSB_FIRST ? r_tx_shift[0] : r_tx_shift[p_WORD_LEN-1];
  assign w_tx_next = p_LSB_FIRST ? (r_tx_shift >> 1) : (r_tx_shift << 1);
  assign w_ld_head = p_LSB_FIRST ? w_tx_word[0] : w_tx_word[p_WORD_LEN-1];
  assign w_ld_next = p_LSB_FIRST ? (w_tx_word >> 1) : (w_tx_word << 1);

  // r_tx_shift always holds the bits not yet presented; each drive edge presents its head.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      o_miso     <= 1'b0;
      o_miso_oe  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ss_fall) begin
            r_state   <= StFrame;
            r_bit_cnt <= '0;
            o_miso_oe <= 1'b1;
            if (!p_CPHA) begin
              o_miso     <= w_ld_head;
              r_tx_shift <= w_ld_next;
            end else begin
              r_tx_shift <= w_tx_word;
            end
          end
        end
        StFrame: begin
          if (w_ss_rise) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            o_miso_oe <= 1'b0;
            o_miso    <= 1'b0;
          end else if (w_sample) begin
            r_rx_shift <= w_rx_word;
            if (w_word_done) begin
              r_bit_cnt  <= '0;
              r_tx_shift <= w_tx_word;
            end else begin
              r_bit_cnt <= r_bit_cnt + CntOne;
            end
          end else if (w_drive) begin
            o_miso     <= w_tx_head;
            r_tx_shift <= w_tx_next;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      o_ovf <= w_ovf_set | (o_ovf & ~i_clr_err);
      o_udf <= w_udf_set | (o_udf & ~i_clr_err);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= inp_data;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < p_FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
    end else if (w_rx_push) begin
      r_rx_mem[r_rx_wr[AW-1:0]] <= w_rx_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PtrOne;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PtrOne;
      if (w_rx_push) r_rx_wr <= r_rx_wr + PtrOne;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PtrOne;
    end
  end

  assign inp_rdy   = !w_tx_full;
  assign out_valid = !w_rx_empty;
  assign out_data  = r_rx_mem[r_rx_rd[AW-1:0]];
  assign o_busy    = (r_state == StFrame);

endmodule
